lsu_ctrl: RTL and testbench

Load/store controller that acts as the initiator on the `memory` block's data port (`data_addr`, `data_rd`, `data_wr`, `din`, `dout`). It accepts one byte/halfword/word request at a time from the CPU pipeline over a valid/ready handshake and sequences the word-only memory port. Sub-word stores use read-modify-write. Each request returns exactly one response pulse with sign/zero-extended load data or an error flag.

---
 rtl/lsu_ctrl_pkg.sv | 30 +++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_ctrl.sv | 135 +++++++++++++
 tb/tb_lsu_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_ctrl_pkg.sv
// Shared encodings for the load/store controller: access sizes, FSM states
// and the alignment rule used to reject a request before it touches memory.
package lsu_defs;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_RESP = 3'd4
   } state_t;

   // Size code 3 counts as misaligned so one check covers both error kinds.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = offset[0];
         SZ_WORD: bad = (offset != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane logic: extracts and extends a load lane from a memory
// word, and merges store data into the addressed lane(s) of that word.
module lsu_align
   import lsu_defs::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic        [4:0]  byte_pos;
   logic        [4:0]  half_pos;
   logic signed [7:0]  lane_b;
   logic signed [15:0] lane_h;

   assign byte_pos = {offset, 3'b000};
   assign half_pos = {offset[1], 4'b0000};

   always_comb begin
      lane_b    = word[byte_pos +: 8];
      lane_h    = word[half_pos +: 16];
      load_data = word;
      case (size)
         SZ_BYTE: load_data = uns ? {24'd0, lane_b} : 32'(lane_b);
         SZ_HALF: load_data = uns ? {16'd0, lane_h} : 32'(lane_h);
         default: load_data = word;
      endcase
   end

   always_comb begin
      store_word = word;
      case (size)
         SZ_BYTE: store_word[byte_pos +: 8]  = wdata[7:0];
         SZ_HALF: store_word[half_pos +: 16] = wdata[15:0];
         default: store_word = wdata;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: one CPU request at a time, sequenced onto a
// word-only memory port, with read-modify-write for sub-word stores.
module lsu_ctrl
   import lsu_defs::*;
#(
   parameter int MEM_BYTES = 4096
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] data_addr,
   output logic        data_rd,
   output logic        data_wr,
   output logic [31:0] din,
   input  logic [31:0] dout
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   state_t      state_q, state_d;
   logic        we_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic [31:0] addr_q;
   logic [31:0] word_q;
   logic [31:0] rdata_q;
   logic        err_q;

   logic        accept;
   logic        req_bad;
   logic [31:0] load_data;
   logic [31:0] store_word;

   assign req_bad = misaligned(req_size, req_addr[1:0]) || (req_addr >= MEM_LIMIT);
   assign accept  = req_valid && req_ready;

   lsu_align u_align (
      .word       (dout),
      .offset     (addr_q[1:0]),
      .size       (size_q),
      .uns        (uns_q),
      .wdata      (word_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Strobes come from the state register alone; ready is held low while reset is active.
   always_comb begin
      state_d    = state_q;
      req_ready  = 1'b0;
      data_rd    = 1'b0;
      data_wr    = 1'b0;
      resp_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = !rst;
            if (req_valid && !rst) begin
               if (req_bad)
                  state_d = S_RESP;
               else if (!req_we || req_size != SZ_WORD)
                  state_d = S_RD;
               else
                  state_d = S_WR;
            end
         end
         S_RD: begin
            data_rd = 1'b1;
            state_d = S_CAP;
         end
         S_CAP: begin
            state_d = we_q ? S_WR : S_RESP;
         end
         S_WR: begin
            data_wr = 1'b1;
            state_d = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // word_q holds the store data until CAP, where sub-word stores swap in the merged word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         size_q  <= SZ_BYTE;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         word_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            word_q  <= req_wdata;
            rdata_q <= '0;
            err_q   <= req_bad;
         end else if (state_q == S_CAP) begin
            if (we_q)
               word_q <= store_word;
            else
               rdata_q <= load_data;
         end
      end
   end

   assign data_addr  = {addr_q[31:2], 2'b00};
   assign din        = word_q;
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl with a behavioural word memory on the data port.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] data_addr;
   logic        data_rd;
   logic        data_wr;
   logic [31:0] din;
   logic [31:0] dout = '0;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mem [0:1023];

   always #5 clk = ~clk;

   lsu_ctrl #(.MEM_BYTES(4096)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .data_addr    (data_addr),
      .data_rd      (data_rd),
      .data_wr      (data_wr),
      .din          (din),
      .dout         (dout)
   );

   always @(posedge clk) begin
      if (data_wr) mem[data_addr[11:2]] <= din;
      if (data_rd) dout <= mem[data_addr[11:2]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic xfer(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                       input logic exp_rd, input logic exp_wr, input logic [31:0] exp_din,
                       input string tag);
      int          lat;
      int          k;
      logic        got, saw_rd, saw_wr, both, err_s;
      logic [31:0] din_s, rdata_s;
      lat = 0; k = 0; got = 0; saw_rd = 0; saw_wr = 0; both = 0;
      err_s = 1'bx; din_s = 'x; rdata_s = 'x;
      @(negedge clk);
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'b1; req_size = 2'd3; req_addr = 32'hFFFF_FFFF; req_wdata = 'x;
      while (!got && k < 8) begin
         k++;
         @(negedge clk);
         if (data_rd) saw_rd = 1'b1;
         if (data_wr) begin
            saw_wr = 1'b1;
            din_s  = din;
         end
         if (data_rd && data_wr) both = 1'b1;
         if (resp_valid) begin
            got = 1'b1; lat = k; rdata_s = resp_rdata; err_s = resp_err;
         end
      end
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rdata_s, exp_rdata);
      chk({tag, " err"}, 32'(err_s), 32'(exp_err));
      chk({tag, " rd_seen"}, 32'(saw_rd), 32'(exp_rd));
      chk({tag, " wr_seen"}, 32'(saw_wr), 32'(exp_wr));
      chk({tag, " rd_wr_both"}, 32'(both), 32'd0);
      if (exp_wr) chk({tag, " din"}, din_s, exp_din);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int saw_resp;
      for (int i = 0; i < 1024; i++) mem[i] = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst req_ready", 32'(req_ready), 32'd0);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_rdata", resp_rdata, 32'd0);
      chk("rst resp_err", 32'(resp_err), 32'd0);
      chk("rst data_addr", data_addr, 32'd0);
      chk("rst data_rd", 32'(data_rd), 32'd0);
      chk("rst data_wr", 32'(data_wr), 32'd0);
      chk("rst din", din, 32'd0);
      rst = 1'b0;
      #1;
      chk("post-rst req_ready", 32'(req_ready), 32'd1);

      // word store / load
      xfer(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 0, 0, 1, 32'hDEADBEEF, "sw 0x10");
      xfer(0, 2'd2, 0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 0, 1, 0, 32'h0, "lw 0x10");

      // byte store merge and byte loads
      xfer(1, 2'd2, 0, 32'h10, 32'h11223344, 2, 32'h0, 0, 0, 1, 32'h11223344, "sw 0x10 b");
      xfer(1, 2'd0, 0, 32'h13, 32'hFFFF_FFA5, 4, 32'h0, 0, 1, 1, 32'hA5223344, "sb 0x13");
      xfer(0, 2'd0, 0, 32'h13, 32'h0, 3, 32'hFFFFFFA5, 0, 1, 0, 32'h0, "lb 0x13");
      xfer(0, 2'd0, 1, 32'h13, 32'h0, 3, 32'h000000A5, 0, 1, 0, 32'h0, "lbu 0x13");
      xfer(0, 2'd0, 1, 32'h10, 32'h0, 3, 32'h00000044, 0, 1, 0, 32'h0, "lbu 0x10");

      // half loads and half store merge
      xfer(1, 2'd2, 0, 32'h10, 32'h80017FFF, 2, 32'h0, 0, 0, 1, 32'h80017FFF, "sw 0x10 h");
      xfer(0, 2'd1, 0, 32'h12, 32'h0, 3, 32'hFFFF8001, 0, 1, 0, 32'h0, "lh 0x12");
      xfer(0, 2'd1, 1, 32'h12, 32'h0, 3, 32'h00008001, 0, 1, 0, 32'h0, "lhu 0x12");
      xfer(0, 2'd1, 0, 32'h10, 32'h0, 3, 32'h00007FFF, 0, 1, 0, 32'h0, "lh 0x10");
      xfer(1, 2'd1, 0, 32'h12, 32'h1234BEEF, 4, 32'h0, 0, 1, 1, 32'hBEEF7FFF, "sh 0x12");

      // top of memory is still in range
      xfer(1, 2'd0, 0, 32'hFFF, 32'h7E, 4, 32'h0, 0, 1, 1, 32'h7E000000, "sb 0xfff");
      xfer(0, 2'd0, 0, 32'hFFF, 32'h0, 3, 32'h0000007E, 0, 1, 0, 32'h0, "lb 0xfff");

      // error requests
      xfer(0, 2'd1, 0, 32'h11, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, "err lh 0x11");
      xfer(1, 2'd2, 0, 32'h12, 32'h55555555, 1, 32'h0, 1, 0, 0, 32'h0, "err sw 0x12");
      xfer(0, 2'd2, 0, 32'h1000, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, "err lw 0x1000");
      xfer(0, 2'd3, 0, 32'h10, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, "err size3");
      xfer(1, 2'd0, 0, 32'h1000, 32'h99, 1, 32'h0, 1, 0, 0, 32'h0, "err sb 0x1000");
      xfer(0, 2'd2, 0, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1, 0, 0, 32'h0, "err lw nowrap");
      xfer(0, 2'd0, 0, 32'h10, 32'h0, 3, 32'hFFFFFFFF, 0, 1, 0, 32'h0, "lb 0x10 after err");

      // reset during the read phase of a byte store
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h5A;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      chk("abort data_rd before", 32'(data_rd), 32'd1);
      rst = 1'b1;
      #1;
      chk("abort data_rd", 32'(data_rd), 32'd0);
      chk("abort data_wr", 32'(data_wr), 32'd0);
      chk("abort resp_valid", 32'(resp_valid), 32'd0);
      chk("abort req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort ready after release", 32'(req_ready), 32'd1);
      saw_resp = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (resp_valid || data_wr) saw_resp = 1;
      end
      chk("abort no response", 32'(saw_resp), 32'd0);
      xfer(0, 2'd2, 0, 32'h10, 32'h0, 3, 32'hBEEF7FFF, 0, 1, 0, 32'h0, "lw after abort");

      // request held valid through RESP is taken from the following IDLE cycle
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
      req_addr = 32'h20; req_wdata = 32'h0BADF00D;
      @(posedge clk);
      #1;
      req_we = 1'b0;
      @(negedge clk);
      chk("b2b wr strobe", 32'(data_wr), 32'd1);
      chk("b2b din", din, 32'h0BADF00D);
      @(negedge clk);
      chk("b2b resp_valid", 32'(resp_valid), 32'd1);
      chk("b2b ready in resp", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("b2b ready after resp", 32'(req_ready), 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("b2b second rd", 32'(data_rd), 32'd1);
      @(negedge clk);
      @(negedge clk);
      chk("b2b second resp_valid", 32'(resp_valid), 32'd1);
      chk("b2b second rdata", resp_rdata, 32'h0BADF00D);
      chk("b2b second err", 32'(resp_err), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
